// File: rtl/onewire_pkg.sv
// Shared 1-Wire timing constants and state encoding for the read/write engines
// and the reset/presence detector.
package onewire_pkg;

   localparam int CLKS_PER_US = 27;
   localparam int NUM_BITS    = 8;

   // Slot timing in microseconds, common to read and write slots.
   localparam int DRIVE_US      = 6;
   localparam int SAMPLE_US     = 14;
   localparam int SLOT_US       = 70;
   localparam int WRITE_LOW0_US = 60;
   localparam int WRITE_LOW1_US = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SLOT = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int us_to_cyc(input int us, input int clks_per_us);
      return us * clks_per_us;
   endfunction

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/onewire_read_if.sv
// Control/pad bundle between the sequencer (master) and the read engine (slave).
interface onewire_read_if #(
   parameter int NUM_BITS = 8
);
   logic                enable;
   logic                bus_in;
   logic                drive_low;
   logic                done;
   logic [NUM_BITS-1:0] data;

   modport master (
      output enable,
      output bus_in,
      input  drive_low,
      input  done,
      input  data
   );

   modport slave (
      input  enable,
      input  bus_in,
      output drive_low,
      output done,
      output data
   );
endinterface

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for the raw 1-Wire line; resets to 1 because the bus idles high.
module onewire_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         dout <= 1'b1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end
endmodule

// File: rtl/onewire_read.sv
// 1-Wire master read engine: NUM_BITS read slots, LSB first, 2-of-3 vote around the sample point.
// done rises NUM_BITS*SLOT_CYC cycles after drive_low first rises; enable low returns to IDLE.
module onewire_read #(
   parameter int CLKS_PER_US = onewire_pkg::CLKS_PER_US,
   parameter int NUM_BITS    = onewire_pkg::NUM_BITS,
   parameter int DRIVE_US    = onewire_pkg::DRIVE_US,
   parameter int SAMPLE_US   = onewire_pkg::SAMPLE_US,
   parameter int SLOT_US     = onewire_pkg::SLOT_US
) (
   input logic           clk,
   input logic           rst,
   onewire_read_if.slave ow
);
   import onewire_pkg::*;

   localparam int DRIVE_CYC  = us_to_cyc(DRIVE_US, CLKS_PER_US);
   localparam int SAMPLE_CYC = us_to_cyc(SAMPLE_US, CLKS_PER_US);
   localparam int SLOT_CYC   = us_to_cyc(SLOT_US, CLKS_PER_US);
   localparam int CNT_W      = $clog2(SLOT_CYC) + 1;
   localparam int IDX_W      = $clog2(NUM_BITS) + 1;
   localparam int SEL_W      = $clog2(NUM_BITS);

   localparam logic [CNT_W-1:0] CNT_DRIVE = CNT_W'(DRIVE_CYC);
   localparam logic [CNT_W-1:0] CNT_SMP0  = CNT_W'(SAMPLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SMP1  = CNT_W'(SAMPLE_CYC);
   localparam logic [CNT_W-1:0] CNT_SMP2  = CNT_W'(SAMPLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_VOTE  = CNT_W'(SAMPLE_CYC + 2);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_BITS - 1);
   localparam logic             DRIVE_AT_START = (DRIVE_CYC > 0);

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_SLOT = 2'(SLOT);
   localparam logic [1:0] ST_DONE = 2'(DONE);

   if (!((DRIVE_CYC + 2 < SAMPLE_CYC) && (SAMPLE_CYC + 2 < SLOT_CYC - 1))) begin : g_bad_timing
      $error("onewire_read: drive/sample/slot timing out of order");
   end

   logic [1:0]          state;
   logic [CNT_W-1:0]    slot_cnt;
   logic [CNT_W-1:0]    slot_nxt;
   logic [IDX_W-1:0]    bit_idx;
   logic [2:0]          samples;
   logic                bus_s;
   logic                drive_low_r;
   logic                done_r;
   logic [NUM_BITS-1:0] data_r;

   onewire_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (ow.bus_in),
      .dout (bus_s)
   );

   assign slot_nxt = slot_cnt + CNT_W'(1);

   // drive_low is computed from the count the next cycle will hold, so the
   // low pulse lines up exactly with slot_cnt 0 .. DRIVE_CYC-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         slot_cnt    <= '0;
         bit_idx     <= '0;
         samples     <= '1;
         drive_low_r <= 1'b0;
         done_r      <= 1'b0;
         data_r      <= '0;
      end else if (!ow.enable) begin
         state       <= ST_IDLE;
         drive_low_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state       <= ST_SLOT;
               slot_cnt    <= '0;
               bit_idx     <= '0;
               data_r      <= '0;
               drive_low_r <= DRIVE_AT_START;
               done_r      <= 1'b0;
            end
            ST_SLOT: begin
               if (slot_cnt == CNT_SMP0) samples[0] <= bus_s;
               if (slot_cnt == CNT_SMP1) samples[1] <= bus_s;
               if (slot_cnt == CNT_SMP2) samples[2] <= bus_s;
               if (slot_cnt == CNT_VOTE) data_r[bit_idx[SEL_W-1:0]] <= maj3(samples);

               if (slot_cnt == CNT_LAST) begin
                  slot_cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
                     state       <= ST_DONE;
                     done_r      <= 1'b1;
                     drive_low_r <= 1'b0;
                  end else begin
                     bit_idx     <= bit_idx + IDX_W'(1);
                     drive_low_r <= DRIVE_AT_START;
                  end
               end else begin
                  slot_cnt    <= slot_nxt;
                  drive_low_r <= (slot_nxt < CNT_DRIVE);
               end
            end
            ST_DONE: begin
               done_r      <= 1'b1;
               drive_low_r <= 1'b0;
            end
            default: begin
               state       <= ST_IDLE;
               drive_low_r <= 1'b0;
               done_r      <= 1'b0;
            end
         endcase
      end
   end

   assign ow.drive_low = drive_low_r;
   assign ow.done      = done_r;
   assign ow.data      = data_r;
endmodule

// File: tb/tb_onewire_read.sv
// Bench for onewire_read: behavioural slave driving the line per slot/offset, model of the
// expected byte from the 2-of-3 sample-window rule, pulse-width and latency monitors.
module tb_onewire_read;
   localparam int NUM_BITS   = 8;
   localparam int DRIVE_CYC  = 6 * 27;
   localparam int SAMPLE_CYC = 14 * 27;
   localparam int SLOT_CYC   = 70 * 27;
   localparam int OP_CYC     = NUM_BITS * SLOT_CYC;
   // The slave drives the pad early by the synchronizer depth so that the level
   // the engine samples at slot offset c is line_at(slot, c).
   localparam int SYNC_LAG   = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   onewire_read_if #(.NUM_BITS(NUM_BITS)) ow();

   onewire_read #(
      .CLKS_PER_US (27),
      .NUM_BITS    (NUM_BITS),
      .DRIVE_US    (6),
      .SAMPLE_US   (14),
      .SLOT_US     (70)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ow  (ow)
   );

   always #5 clk = ~clk;

   // slave configuration: mode 0 = byte pattern, 1 = never pulls low, 2 = holds low
   int         mode = 0;
   logic [7:0] slave_byte = 8'h00;
   int         lo_start = 170;
   int         lo_end = 900;
   int         g_bit = -1;
   int         g_start = 0;
   int         g_len = 0;

   function automatic logic line_at(input int slot, input int c);
      logic lvl;
      lvl = 1'b1;
      if (mode == 1) return 1'b1;
      if (mode == 2) return 1'b0;
      if (slot < 0 || slot >= NUM_BITS || c >= SLOT_CYC) return 1'b1;
      if (((slave_byte >> slot) & 8'd1) == 8'd0 && c >= lo_start && c <= lo_end) lvl = 1'b0;
      if (slot == g_bit && c >= g_start && c < g_start + g_len) lvl = 1'b0;
      return lvl;
   endfunction

   function automatic logic [7:0] expected_byte();
      logic [7:0] e;
      int lows;
      e = 8'h00;
      for (int b = 0; b < NUM_BITS; b++) begin
         lows = 0;
         for (int c = SAMPLE_CYC - 1; c <= SAMPLE_CYC + 1; c++)
            if (!line_at(b, c)) lows++;
         e[b] = (lows >= 2) ? 1'b0 : 1'b1;
      end
      return e;
   endfunction

   // slave: a rising drive_low marks a slot start; offset counted from there
   int   sidx = -1;
   int   scnt = 0;
   logic prev_dl = 1'b0;
   always begin
      @(posedge clk);
      #1;
      if (rst || !ow.enable) begin
         sidx = -1;
         scnt = 0;
      end else if (ow.drive_low && !prev_dl) begin
         sidx++;
         scnt = 0;
      end else begin
         scnt++;
      end
      prev_dl   = ow.drive_low;
      ow.bus_in = line_at(sidx, scnt + SYNC_LAG);
   end

   // drive_low pulse monitor (monotonic totals)
   int run_len = 0;
   int pulse_total = 0;
   int bad_width_total = 0;
   int dl_in_done_total = 0;
   always begin
      @(posedge clk);
      #1;
      if (ow.drive_low) begin
         run_len++;
         if (ow.done) dl_in_done_total++;
      end else if (run_len > 0) begin
         pulse_total++;
         if (run_len != DRIVE_CYC) bad_width_total++;
         run_len = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(output int lat, output bit ok);
      int t0;
      t0  = -1;
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < OP_CYC + 200; i++) begin
         tick();
         if (ow.drive_low && t0 < 0) t0 = i;
         if (ow.done) begin
            ok  = 1'b1;
            lat = i - t0;
            break;
         end
      end
   endtask

   task automatic wait_slot(input int slot, input int cnt, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < OP_CYC; i++) begin
         tick();
         if (sidx == slot && scnt == cnt) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ow.enable = 1'b0;
      repeat (3) tick();
      checks++;
      if (ow.drive_low !== 1'b0) begin errors++; $display("FAIL reset_drive_low got %b want 0", ow.drive_low); end
      checks++;
      if (ow.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", ow.done); end
      checks++;
      if (ow.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", ow.data); end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_a5_and_hold();
      int lat, p0, b0, d0, hold_bad, hi_cnt;
      bit ok;
      logic [7:0] exp, snap;
      mode = 0; slave_byte = 8'hA5; lo_start = 170; lo_end = 900; g_bit = -1;
      exp = expected_byte();
      p0 = pulse_total; b0 = bad_width_total; d0 = dl_in_done_total;
      ow.enable = 1'b1;
      wait_done(lat, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL a5_done_timeout got none want done"); end
      checks++;
      if (ow.data !== exp || exp !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want %h", ow.data, exp); end
      checks++;
      if (lat != OP_CYC) begin errors++; $display("FAIL a5_latency got %0d want %0d", lat, OP_CYC); end
      checks++;
      if (pulse_total - p0 != NUM_BITS) begin errors++; $display("FAIL a5_pulse_count got %0d want %0d", pulse_total - p0, NUM_BITS); end
      checks++;
      if (bad_width_total != b0) begin errors++; $display("FAIL a5_pulse_width got %0d bad want 0", bad_width_total - b0); end
      snap = ow.data; hold_bad = 0; hi_cnt = 0; p0 = pulse_total;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (ow.done !== 1'b1 || ow.data !== snap) hold_bad++;
         if (ow.drive_low) hi_cnt++;
      end
      checks++;
      if (hold_bad != 0) begin errors++; $display("FAIL hold_done_data got %0d bad cycles want 0", hold_bad); end
      checks++;
      if (hi_cnt != 0 || pulse_total != p0) begin errors++; $display("FAIL hold_drive_low got %0d high cycles want 0", hi_cnt); end
      checks++;
      if (dl_in_done_total != d0) begin errors++; $display("FAIL drive_low_in_done got %0d want 0", dl_in_done_total - d0); end
      ow.enable = 1'b0;
      tick();
      checks++;
      if (ow.done !== 1'b0) begin errors++; $display("FAIL hold_drop_done got %b want 0", ow.done); end
      tick();
   endtask

   task automatic test_const(input int m, input logic [7:0] want);
      int lat;
      bit ok;
      mode = m;
      ow.enable = 1'b1;
      wait_done(lat, ok);
      checks++;
      if (!ok || ow.done !== 1'b1) begin errors++; $display("FAIL const%0d_done got %b want 1", m, ow.done); end
      checks++;
      if (ow.data !== want) begin errors++; $display("FAIL const%0d_data got %h want %h", m, ow.data, want); end
      ow.enable = 1'b0;
      mode = 0;
      repeat (4) tick();
   endtask

   task automatic test_abort_reenable();
      int lat, hi;
      bit ok;
      logic [7:0] exp;
      mode = 0;
      slave_byte = 8'($urandom) | 8'h08;
      lo_start = $urandom_range(370, 170);
      lo_end = $urandom_range(1800, 381);
      g_bit = 3; g_start = SAMPLE_CYC; g_len = 1;
      exp = expected_byte();
      ow.enable = 1'b1;
      wait_slot(4, 100, ok);
      checks++;
      if (!ok || ow.drive_low !== 1'b1) begin errors++; $display("FAIL abort_reach_slot4 got %b want drive_low 1", ow.drive_low); end
      ow.enable = 1'b0;
      tick();
      checks++;
      if (ow.drive_low !== 1'b0) begin errors++; $display("FAIL abort_drive_low got %b want 0", ow.drive_low); end
      checks++;
      if (ow.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", ow.done); end
      checks++;
      if (ow.data !== (exp & 8'h0F)) begin errors++; $display("FAIL abort_partial got %h want %h", ow.data, exp & 8'h0F); end
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ow.drive_low) hi++;
      end
      checks++;
      if (hi != 0) begin errors++; $display("FAIL abort_idle got %0d high cycles want 0", hi); end
      ow.enable = 1'b1;
      wait_done(lat, ok);
      checks++;
      if (!ok || ow.data !== exp) begin errors++; $display("FAIL reenable_data got %h want %h", ow.data, exp); end
      checks++;
      if (ow.data[3] !== 1'b1) begin errors++; $display("FAIL glitch1_bit3 got %b want 1", ow.data[3]); end
      ow.enable = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_rst_mid();
      int lat;
      bit ok;
      logic [7:0] exp;
      mode = 0;
      slave_byte = 8'($urandom) | 8'h08;
      lo_start = $urandom_range(370, 170);
      lo_end = $urandom_range(1800, 381);
      g_bit = 3; g_start = SAMPLE_CYC - 1; g_len = 2;
      exp = expected_byte();
      ow.enable = 1'b1;
      wait_slot(2, 500, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_reach_slot2 got timeout want slot 2"); end
      rst = 1'b1;
      tick();
      checks++;
      if (ow.drive_low !== 1'b0 || ow.done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got dl=%b done=%b want 0 0", ow.drive_low, ow.done); end
      checks++;
      if (ow.data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", ow.data); end
      rst = 1'b0;
      wait_done(lat, ok);
      checks++;
      if (!ok || lat != OP_CYC) begin errors++; $display("FAIL rst_restart_latency got %0d want %0d", lat, OP_CYC); end
      checks++;
      if (ow.data !== exp) begin errors++; $display("FAIL rst_restart_data got %h want %h", ow.data, exp); end
      checks++;
      if (ow.data[3] !== 1'b0) begin errors++; $display("FAIL glitch2_bit3 got %b want 0", ow.data[3]); end
      ow.enable = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      rst = 1'b1;
      ow.enable = 1'b0;
      test_reset();
      test_a5_and_hold();
      test_const(1, 8'hFF);
      test_const(2, 8'h00);
      test_abort_reenable();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/onewire_read.md
Name: onewire_read

Overview:
- 1-Wire master read engine: issues NUM_BITS read time slots on the shared bus and assembles the bits returned by the slave, LSB first.
- Complements the master byte-write engine. Both share the same open-drain pad control: drive_low=1 pulls the bus low, drive_low=0 releases it.
- The sequencer above muxes drive_low from the write and read engines and selects one engine's enable at a time.

Parameters:
- CLKS_PER_US, 27, clock cycles per microsecond.
- NUM_BITS, 8, read slots per operation.
- DRIVE_US, 6, master low pulse at slot start.
- SAMPLE_US, 14, sample point measured from slot start.
- SLOT_US, 70, total slot length including recovery.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  level request. High starts and holds the operation; low aborts or clears.
- bus_in  in  1  raw 1-Wire line level (asynchronous).
- drive_low  out  1  1 = pull bus low.
- done  out  1  operation complete; data valid.
- data  out  NUM_BITS  received bits; bit i = slot i.

Behaviour:
- Derived constants:
  - DRIVE_CYC = DRIVE_US*CLKS_PER_US (162)
  - SAMPLE_CYC = SAMPLE_US*CLKS_PER_US (378)
  - SLOT_CYC = SLOT_US*CLKS_PER_US (1890)
  - Elaboration error unless DRIVE_CYC+2 < SAMPLE_CYC and SAMPLE_CYC+2 < SLOT_CYC-1.
- Reset (rst=1 at posedge): state=IDLE, slot_cnt=0, bit_idx=0, drive_low=0, done=0, data=0, synchronizer flops=1 (bus idles high).
- Input path: bus_in passes through a 2-flop synchronizer (bus_s). The 2-cycle lag is accepted and is not compensated.
- States:
  - IDLE:
    - done=0, drive_low=0.
    - enable=1 → SLOT; slot_cnt=0, bit_idx=0, data=0.
  - SLOT:
    - slot_cnt increments every cycle.
    - drive_low = (slot_cnt < DRIVE_CYC), registered: exactly DRIVE_CYC cycles low per slot, starting the cycle after entry.
    - bus_s is captured at slot_cnt = SAMPLE_CYC-1, SAMPLE_CYC and SAMPLE_CYC+1.
    - At slot_cnt = SAMPLE_CYC+2, data[bit_idx] is written with the 2-of-3 majority of those samples.
    - At slot_cnt = SLOT_CYC-1: slot_cnt=0. If bit_idx = NUM_BITS-1, go to DONE; otherwise bit_idx+1.
  - DONE:
    - done=1, drive_low=0, data held stable.
    - Stays in DONE while enable=1. No re-trigger without enable going low first.
    - enable=0 → IDLE; done clears on that edge.
- Latency: done rises NUM_BITS*SLOT_CYC cycles after drive_low first rises (15120 at defaults).
- enable low mid-operation (any state other than IDLE): next edge → IDLE, drive_low=0, done=0. data keeps the partial contents but is not valid.
- rst wins over enable on the same edge.
- Bus held low by a slave through the sample window: bit=0. Never pulled low: bit=1. A single-cycle glitch inside the window is voted out.
- drive_low is never high in DONE or IDLE, and never high at or after slot_cnt = DRIVE_CYC.
- Counter width: $clog2(SLOT_CYC)+1 bits. bit_idx width: $clog2(NUM_BITS)+1 bits. No wrap beyond SLOT_CYC-1.

Decomposition:
- Package onewire_pkg holds:
  - CLKS_PER_US
  - DRIVE/SAMPLE/SLOT/WRITE timing constants in µs, shared with the write engine
  - state enum (IDLE, SLOT, DONE)
- One sub-module, onewire_sync: 2-flop synchronizer with reset value 1. It is reused later by the reset/presence detector.

Test Plan:
- Slave model returns 0xA5, bus driven low from slot_cnt 170 to 900 for 0-bits; enable held → done after 15120 cycles of drive_low activity, data=0xA5, drive_low high exactly 162 cycles in each of 8 slots.
- No slave (bus_in constant 1) → data=0xFF, done=1. Constant 0 → data=0x00.
- bus_in for bit 3 pulses low for only 1 cycle at slot_cnt=378 on a 1-bit → majority keeps bit 3 = 1. Two-cycle low at 377–378 → bit 3 = 0.
- Deassert enable at slot 4, slot_cnt=100 → next cycle drive_low=0, done=0, state IDLE. Re-enable → full fresh read, correct byte.
- Assert rst during slot 2 with enable=1 → all outputs zero next cycle. Release rst with enable still 1 → new operation starts from bit 0.
- After done, hold enable 5000 cycles → done stays 1, data stable, no drive_low pulses. Drop enable → done=0 next cycle.
